qed_dup_sequencer: RTL and testbench
====================================

Name: qed_dup_sequencer

Overview:
- Sits between the constrained instruction source and the core's instruction-fetch port in the QED wrapper.
- ORIG phase: passes original instructions through to the core and records them in a FIFO.
- DUP phase: replays the recorded instructions, rewritten into the duplicate register and memory half (registers +16, load/store immediates +MEM_OFFSET).
- Raises sif_commit once every original has been re-issued as its duplicate.

Parameters:
DEPTH, 16, FIFO entries (power of 2); counters are $clog2(DEPTH)+1 bits wide
REG_OFFSET, 16, added to each nonzero rd/rs1/rs2 field in duplicates
MEM_OFFSET, 64, added to 12-bit load/store immediate in duplicates
NOP_INSTR, 32'h0000007F, QED NOP (opcode 7'b1111111)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
ena  input  1  core requests an instruction this cycle
exec_dup  input  1  request to leave ORIG phase (free input)
ifu_qed_instruction  input  32  constrained original instruction
qed_ifu_instruction  output  32  instruction delivered to core
vld_out  output  1  qed_ifu_instruction is new this cycle
dup_mode  output  1  high in DUP and DONE
sif_commit  output  1  sticky; all duplicates issued
orig_count  output  $clog2(DEPTH)+1  originals issued (NOPs excluded)
dup_count  output  $clog2(DEPTH)+1  duplicates issued

Behaviour:
- All outputs registered; 1-cycle latency from an ena edge to qed_ifu_instruction/vld_out.
- Reset (rst high at a clk edge, any state):
  - state=ORIG, FIFO emptied, orig_count=dup_count=0.
  - qed_ifu_instruction=NOP_INSTR; vld_out, dup_mode, sif_commit all 0.
- ena low: no state, FIFO or counter change; vld_out=0 next cycle; qed_ifu_instruction holds its value.
- State ORIG, ena high:
  - exec_dup=1 and FIFO non-empty: input is dropped, NOP_INSTR is emitted, go to DUP.
  - exec_dup=1 and FIFO empty: exec_dup is ignored.
  - Otherwise, input opcode == 7'h7F: passed through, not pushed, counters unchanged.
  - Otherwise (non-NOP): passed through unchanged, pushed, orig_count+1. If this push fills the FIFO, go to DUP at the same edge.
- State DUP, ena high:
  - Pop head; emit its rewritten form; dup_count+1; ifu_qed_instruction is ignored.
  - When the pop empties the FIFO, go to DONE. sif_commit=1 in the same cycle the last duplicate appears on the output.
- State DONE:
  - ena emits NOP_INSTR; counters frozen.
  - sif_commit and dup_mode stay 1 until rst.
- Rewrite rules (combinational on FIFO head):
  - Any register field equal to 0 stays 0; every other register field becomes field+REG_OFFSET (5-bit).
  - R (0110011): rd, rs1, rs2.
  - OP-IMM (0010011), JALR (1100111): rd, rs1.
  - LOAD (0000011): rd, rs1; imm[31:20] += MEM_OFFSET, mod 2^12.
  - STORE (0100011): rs1, rs2; {imm[31:25],imm[11:7]} += MEM_OFFSET, mod 2^12.
  - BRANCH (1100011): rs1, rs2.
  - LUI (0110111), AUIPC (0010111), JAL (1101111): rd.
  - SYSTEM, FENCE, other opcodes: unchanged.
- Invariants:
  - dup_count <= orig_count always.
  - sif_commit=1 implies orig_count==dup_count and orig_count>0.
  - FIFO never overflows.

Test Plan:
- ORIG, ena, in=0x002081B3 (ADD x3,x1,x2) -> next cycle out=0x002081B3, vld_out=1, orig_count=1. Then ena+exec_dup -> out=0x0000007F, dup_mode=1. Then ena -> out=0x012889B3 (ADD x19,x17,x18), dup_count=1, sif_commit=1.
- ORIG, ena, in=0x00802283 (LW x5,8(x0)); exec_dup; ena -> duplicate out=0x04802A83 (LW x21,72(x0)); rs1 x0 unchanged.
- 16 non-NOP ADDIs with ena, exec_dup=0 -> dup_mode=1 right after the 16th push. 17th ena -> rewritten first ADDI. After 16 dup pops -> sif_commit=1, dup_count=16.
- exec_dup=1 with FIFO empty, in=0x002081B3 -> passed through, orig_count=1, dup_mode=0.
- in=0x0000007F in ORIG -> out=0x0000007F, vld_out=1, orig_count stays 0.
- rst during DUP with 3 entries pending -> next cycle dup_mode=0, sif_commit=0, counts=0, out=0x0000007F. Next ena with in=0x002081B3 is treated as an original.

Source files
------------

// File: rtl/qed_dup_sequencer.sv
// QED duplicate sequencer: forwards original instructions to the core while
// recording them, then replays them rewritten into the duplicate register/memory half.
module qed_dup_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned REG_OFFSET = 16,
  parameter int unsigned MEM_OFFSET = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000007F
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       exec_dup,
  input  logic [31:0]                ifu_qed_instruction,
  output logic [31:0]                qed_ifu_instruction,
  output logic                       vld_out,
  output logic                       dup_mode,
  output logic                       sif_commit,
  output logic [$clog2(DEPTH):0]     orig_count,
  output logic [$clog2(DEPTH):0]     dup_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ST_ORIG = 2'd0;
  localparam logic [1:0] ST_DUP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
  localparam logic [4:0]    REG_OFF5  = 5'(REG_OFFSET);
  localparam logic [11:0]   MEM_OFF12 = 12'(MEM_OFFSET);

  logic [1:0]    state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic          vld_q, vld_d;
  logic          commit_q, commit_d;
  logic [CW-1:0] orig_q, orig_d;
  logic [CW-1:0] dup_q, dup_d;
  logic          push_en;
  logic [31:0]   fifo_mem [DEPTH];
  logic [31:0]   head;
  logic          fifo_empty;

  // The issue counters double as FIFO pointers: every push bumps orig, every pop bumps dup.
  assign head       = fifo_mem[dup_q[AW-1:0]];
  assign fifo_empty = (orig_q == dup_q);

  function automatic logic [4:0] shift_reg(input logic [4:0] f);
    return (f == 5'd0) ? 5'd0 : f + REG_OFF5;
  endfunction

  function automatic logic [31:0] dup_rewrite(input logic [31:0] ins);
    logic [31:0] r;
    logic [11:0] imm;
    r   = ins;
    imm = 12'd0;
    case (ins[6:0])
      7'b0110011: begin
        r[11:7]  = shift_reg(ins[11:7]);
        r[19:15] = shift_reg(ins[19:15]);
        r[24:20] = shift_reg(ins[24:20]);
      end
      7'b0010011, 7'b1100111: begin
        r[11:7]  = shift_reg(ins[11:7]);
        r[19:15] = shift_reg(ins[19:15]);
      end
      7'b0000011: begin
        r[11:7]  = shift_reg(ins[11:7]);
        r[19:15] = shift_reg(ins[19:15]);
        imm      = ins[31:20] + MEM_OFF12;
        r[31:20] = imm;
      end
      7'b0100011: begin
        r[19:15] = shift_reg(ins[19:15]);
        r[24:20] = shift_reg(ins[24:20]);
        imm      = {ins[31:25], ins[11:7]} + MEM_OFF12;
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      7'b1100011: begin
        r[19:15] = shift_reg(ins[19:15]);
        r[24:20] = shift_reg(ins[24:20]);
      end
      7'b0110111, 7'b0010111, 7'b1101111: r[11:7] = shift_reg(ins[11:7]);
      default: r = ins;
    endcase
    return r;
  endfunction

  // NOTE: every signal gets a default at the top of the block so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    vld_d    = 1'b0;
    commit_d = commit_q;
    orig_d   = orig_q;
    dup_d    = dup_q;
    push_en  = 1'b0;
    if (ena) begin
      vld_d = 1'b1;
      case (state_q)
        ST_ORIG: begin
          if (exec_dup && !fifo_empty) begin
            instr_d = NOP_INSTR;
            state_d = ST_DUP;
          end else begin
            instr_d = ifu_qed_instruction;
            if (ifu_qed_instruction[6:0] != 7'h7F) begin
              push_en = 1'b1;
              orig_d  = orig_q + 1'b1;
              if (orig_q == LAST_SLOT) state_d = ST_DUP;
            end
          end
        end
        ST_DUP: begin
          instr_d = dup_rewrite(head);
          dup_d   = dup_q + 1'b1;
          if (dup_q + 1'b1 == orig_q) begin
            state_d  = ST_DONE;
            commit_d = 1'b1;
          end
        end
        default: instr_d = NOP_INSTR;
      endcase
    end
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ORIG;
      instr_q  <= NOP_INSTR;
      vld_q    <= 1'b0;
      commit_q <= 1'b0;
      orig_q   <= '0;
      dup_q    <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
      commit_q <= commit_d;
      orig_q   <= orig_d;
      dup_q    <= dup_d;
    end
  end

  // NOTE: storage has no reset; emptiness comes from the counters, so stale data is never read.
  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[orig_q[AW-1:0]] <= ifu_qed_instruction;
  end

  assign qed_ifu_instruction = instr_q;
  assign vld_out             = vld_q;
  assign dup_mode            = (state_q != ST_ORIG);
  assign sif_commit          = commit_q;
  assign orig_count          = orig_q;
  assign dup_count           = dup_q;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Scoreboard bench for qed_dup_sequencer: a queue-based behavioural model predicts
// every registered output, plus fixed vectors for the documented scenarios.
module tb_qed_dup_sequencer;

  localparam int DEPTH = 16;
  localparam logic [31:0] NOP = 32'h0000007F;
  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'h00802283;

  logic        clk = 1'b0;
  logic        rst, ena, exec_dup;
  logic [31:0] ifu_qed_instruction, qed_ifu_instruction;
  logic        vld_out, dup_mode, sif_commit;
  logic [4:0]  orig_count, dup_count;

  always #5 clk = ~clk;

  qed_dup_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .ena                 (ena),
    .exec_dup            (exec_dup),
    .ifu_qed_instruction (ifu_qed_instruction),
    .qed_ifu_instruction (qed_ifu_instruction),
    .vld_out             (vld_out),
    .dup_mode            (dup_mode),
    .sif_commit          (sif_commit),
    .orig_count          (orig_count),
    .dup_count           (dup_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        dm;
    logic        sc;
    logic [4:0]  oc;
    logic [4:0]  dc;
  } obs_t;

  obs_t        sb[$];
  obs_t        exp_o, got_o;
  int          n_cmp = 0;
  int          n_bad = 0;

  int          m_st;
  logic [31:0] m_fifo[$];
  int          m_orig, m_dup;
  logic [31:0] m_out;
  logic        m_vld, m_commit;

  function automatic logic [31:0] ref_dup(input logic [31:0] i);
    logic [31:0] o;
    logic [11:0] im;
    bit has_rd, has_rs1, has_rs2;
    o = i;
    has_rd = 0; has_rs1 = 0; has_rs2 = 0;
    case (i[6:0])
      7'h33:               begin has_rd = 1; has_rs1 = 1; has_rs2 = 1; end
      7'h13, 7'h67, 7'h03: begin has_rd = 1; has_rs1 = 1; end
      7'h23, 7'h63:        begin has_rs1 = 1; has_rs2 = 1; end
      7'h37, 7'h17, 7'h6F: has_rd = 1;
      default: ;
    endcase
    if (has_rd  && i[11:7]  != 0) o[11:7]  = i[11:7]  + 5'd16;
    if (has_rs1 && i[19:15] != 0) o[19:15] = i[19:15] + 5'd16;
    if (has_rs2 && i[24:20] != 0) o[24:20] = i[24:20] + 5'd16;
    if (i[6:0] == 7'h03) o[31:20] = i[31:20] + 12'd64;
    if (i[6:0] == 7'h23) begin
      im = {i[31:25], i[11:7]} + 12'd64;
      o[31:25] = im[11:5];
      o[11:7]  = im[4:0];
    end
    return o;
  endfunction

  function automatic obs_t observed();
    return '{instr: qed_ifu_instruction, vld: vld_out, dm: dup_mode,
             sc: sif_commit, oc: orig_count, dc: dup_count};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] ops [10];
    ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 9) == 0) r[6:0] = 7'h7F;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; exec_dup = 1'b0; ifu_qed_instruction = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_st = 0; m_fifo.delete(); m_orig = 0; m_dup = 0;
    m_out = NOP; m_vld = 1'b0; m_commit = 1'b0;
  endtask

  task automatic drive(input logic e, input logic x, input logic [31:0] ins);
    logic [31:0] h;
    ena = e; exec_dup = x; ifu_qed_instruction = ins;
    m_vld = e;
    if (e) begin
      case (m_st)
        0: begin
          if (x && m_fifo.size() != 0) begin
            m_out = NOP; m_st = 1;
          end else begin
            m_out = ins;
            if (ins[6:0] != 7'h7F) begin
              m_fifo.push_back(ins); m_orig++;
              if (m_fifo.size() == DEPTH) m_st = 1;
            end
          end
        end
        1: begin
          h = m_fifo.pop_front();
          m_out = ref_dup(h); m_dup++;
          if (m_fifo.size() == 0) begin m_st = 2; m_commit = 1'b1; end
        end
        default: m_out = NOP;
      endcase
    end
    sb.push_back('{instr: m_out, vld: m_vld, dm: (m_st != 0), sc: m_commit,
                   oc: 5'(m_orig), dc: 5'(m_dup)});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (qed_ifu_instruction !== NOP || vld_out !== 1'b0 || dup_mode !== 1'b0 ||
        sif_commit !== 1'b0 || orig_count !== 5'd0 || dup_count !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_state: got out=%h vld=%b dm=%b sc=%b oc=%0d dc=%0d, expected out=%h and all others 0",
               qed_ifu_instruction, vld_out, dup_mode, sif_commit, orig_count, dup_count, NOP);
    end
  endtask

  task automatic test_add_flow();
    logic [31:0] ins [3] = '{ADD, 32'h00A00513, 32'h00B00593};
    logic        xd  [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, xd[k], ins[k]);
      exp_o = sb.pop_front(); got_o = observed(); n_cmp++;
      if (got_o !== exp_o) begin
        n_bad++;
        $display("FAIL add_flow step %0d: got %p, expected %p", k, got_o, exp_o);
      end
    end
    n_cmp++;
    if (qed_ifu_instruction !== 32'h012889B3 || sif_commit !== 1'b1 || dup_count !== 5'd1) begin
      n_bad++;
      $display("FAIL add_dup_vector: got out=%h sc=%b dc=%0d, expected out=012889b3 sc=1 dc=1",
               qed_ifu_instruction, sif_commit, dup_count);
    end
  endtask

  task automatic test_load();
    do_reset();
    drive(1'b1, 1'b0, LW);
    drive(1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) void'(sb.pop_front());
    n_cmp++;
    if (qed_ifu_instruction !== 32'h04802A83 || vld_out !== 1'b1) begin
      n_bad++;
      $display("FAIL load_dup_vector: got out=%h vld=%b, expected out=04802a83 vld=1",
               qed_ifu_instruction, vld_out);
    end
  endtask

  task automatic test_fill();
    logic [31:0] addi;
    do_reset();
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      addi = $urandom;
      addi[6:0] = 7'h13;
      drive(1'b1, 1'b0, addi);
      exp_o = sb.pop_front(); got_o = observed(); n_cmp++;
      if (got_o !== exp_o) begin
        n_bad++;
        $display("FAIL fill step %0d: got %p, expected %p", k, got_o, exp_o);
      end
      if (k == DEPTH - 1) begin
        n_cmp++;
        if (dup_mode !== 1'b1 || orig_count !== 5'd16) begin
          n_bad++;
          $display("FAIL fill_enters_dup: got dm=%b oc=%0d, expected dm=1 oc=16", dup_mode, orig_count);
        end
      end
    end
    n_cmp++;
    if (sif_commit !== 1'b1 || dup_count !== 5'd16 || qed_ifu_instruction !== NOP) begin
      n_bad++;
      $display("FAIL fill_done: got sc=%b dc=%0d out=%h, expected sc=1 dc=16 out=%h",
               sif_commit, dup_count, qed_ifu_instruction, NOP);
    end
  endtask

  task automatic test_exec_empty();
    do_reset();
    drive(1'b1, 1'b1, ADD);
    exp_o = sb.pop_front(); got_o = observed(); n_cmp++;
    if (got_o !== exp_o || orig_count !== 5'd1 || dup_mode !== 1'b0) begin
      n_bad++;
      $display("FAIL exec_dup_empty: got %p, expected %p", got_o, exp_o);
    end
  endtask

  task automatic test_nop_pass();
    do_reset();
    drive(1'b1, 1'b0, NOP);
    exp_o = sb.pop_front(); got_o = observed(); n_cmp++;
    if (got_o !== exp_o || qed_ifu_instruction !== NOP || vld_out !== 1'b1 || orig_count !== 5'd0) begin
      n_bad++;
      $display("FAIL nop_passthrough: got %p, expected %p", got_o, exp_o);
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    drive(1'b1, 1'b0, ADD);
    drive(1'b0, 1'b1, LW);
    void'(sb.pop_front());
    exp_o = sb.pop_front(); got_o = observed(); n_cmp++;
    if (got_o !== exp_o || qed_ifu_instruction !== ADD || vld_out !== 1'b0 || orig_count !== 5'd1) begin
      n_bad++;
      $display("FAIL idle_hold: got %p, expected %p", got_o, exp_o);
    end
  endtask

  task automatic test_reset_in_dup();
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, ADD + (k << 7));
    drive(1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    sb.delete();
    do_reset();
    n_cmp++;
    if (dup_mode !== 1'b0 || sif_commit !== 1'b0 || orig_count !== 5'd0 ||
        dup_count !== 5'd0 || qed_ifu_instruction !== NOP) begin
      n_bad++;
      $display("FAIL reset_in_dup: got dm=%b sc=%b oc=%0d dc=%0d out=%h, expected 0 0 0 0 %h",
               dup_mode, sif_commit, orig_count, dup_count, qed_ifu_instruction, NOP);
    end
    drive(1'b1, 1'b0, ADD);
    exp_o = sb.pop_front(); got_o = observed(); n_cmp++;
    if (got_o !== exp_o || qed_ifu_instruction !== ADD || orig_count !== 5'd1) begin
      n_bad++;
      $display("FAIL post_reset_original: got %p, expected %p", got_o, exp_o);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 60; k++) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rand_instr());
        exp_o = sb.pop_front(); got_o = observed(); n_cmp++;
        if (got_o !== exp_o) begin
          n_bad++;
          $display("FAIL random r%0d c%0d: got %p, expected %p", r, k, got_o, exp_o);
        end
        n_cmp++;
        if (dup_count > orig_count || (sif_commit && (orig_count != dup_count || orig_count == 0))) begin
          n_bad++;
          $display("FAIL invariant r%0d c%0d: got oc=%0d dc=%0d sc=%b, required dc<=oc and commit consistency",
                   r, k, orig_count, dup_count, sif_commit);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_flow();
    test_load();
    test_fill();
    test_exec_empty();
    test_nop_pass();
    test_idle_hold();
    test_reset_in_dup();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
